// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, FSM states
// and small decode helpers used by both the controller and the datapath.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_MULTU = 2'd0,
        MD_MULT  = 2'd1,
        MD_DIVU  = 2'd2,
        MD_DIV   = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_if.sv
// Controller-side bus of the multiply/divide unit. Handshake: start is a level that is
// only acted on while busy is low; done is a one-cycle pulse with HI/LO already updated.
interface md_if #(
    parameter int WIDTH = 32
);
    import md_pkg::*;

    logic             start;
    logic [1:0]       md_op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    md_state_e        state_dbg;

    modport master (
        output start, md_op, rs_val, rt_val, hi_we, lo_we, wdata,
        input  hi, lo, busy, done, state_dbg
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, hi_we, lo_we, wdata,
        output hi, lo, busy, done, state_dbg
    );

endinterface

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a shared
// 2*WIDTH accumulator ({upper, lower} for multiply, {remainder, quotient} for divide).
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;

    always_comb begin
        addend = acc_i[0] ? opnd_i : {WIDTH{1'b0}};
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        // Remainder stays below the divisor, so WIDTH bits hold it; the shift needs one more.
        rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, opnd_i});
        diff   = rem_sh[WIDTH-1:0] - opnd_i;
        if (is_div_i) begin
            acc_o = {(ge ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Operands are made non-negative at launch; signs are restored in the FIX state.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    md_if.slave  bus
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    md_op_e             op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    md_op_e             in_op;
    logic               in_signed;
    logic [WIDTH-1:0]   rs_abs;
    logic [WIDTH-1:0]   rt_abs;
    logic [2*WIDTH-1:0] step_acc;
    logic               res_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (op_is_div(op_q)),
        .acc_o    (step_acc)
    );

    always_comb begin
        in_op     = md_op_e'(bus.md_op);
        in_signed = op_is_signed(in_op);
        rs_abs    = (in_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
        rt_abs    = (in_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
        res_neg   = sign_a_q ^ sign_b_q;
        prod_fix  = res_neg ? -acc_q : acc_q;
        quo_fix   = res_neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // Remainder takes the dividend's sign; with a zero divisor this rebuilds rs_val.
        rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d     = in_op;
                    sign_a_d = in_signed & bus.rs_val[WIDTH-1];
                    sign_b_d = in_signed & bus.rt_val[WIDTH-1];
                    div0_d   = op_is_div(in_op) && (bus.rt_val == '0);
                    cnt_d    = '0;
                    if (op_is_div(in_op)) begin
                        acc_d  = {{WIDTH{1'b0}}, rs_abs};
                        opnd_d = rt_abs;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, rt_abs};
                        opnd_d = rs_abs;
                    end
                    state_d = S_CALC;
                end else begin
                    if (bus.hi_we) hi_d = bus.wdata;
                    if (bus.lo_we) lo_d = bus.wdata;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_is_div(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= MD_MULTU;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: drivers push expected {HI,LO} and done edge into
// queues; a negedge monitor pops and compares whenever done is seen.
module tb_mult_div_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];
    logic [63:0] mon_exp;
    int          mon_lat;

    md_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: return 64'(ua * ub);
            2'd1: return 64'(sa * sb);
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {32'(sr), 32'(sq)};
            end
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (!rst || exp_q.size() == 0) begin
                flag("unexpected_done");
            end else begin
                mon_exp = exp_q.pop_front();
                mon_lat = lat_q.pop_front();
                chk("hi", {32'd0, bus.hi}, {32'd0, mon_exp[63:32]});
                chk("lo", {32'd0, bus.lo}, {32'd0, mon_exp[31:0]});
                chk("done_edge", 64'(cyc), 64'(mon_lat));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic lo_w, input logic [31:0] wd);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.lo_we  = lo_w;
        bus.wdata  = wd;
        exp_q.push_back(ref_model(op, a, b));
        lat_q.push_back(cyc + 34);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
    endtask

    task automatic wait_done(input int exp_busy);
        int i;
        int bcount;
        bcount = 0;
        for (i = 0; i < 60; i++) begin
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) bcount++;
            @(negedge clk);
        end
        if (i == 60) flag("done_timeout");
        else chk("busy_cycles", 64'(bcount), 64'(exp_busy));
    endtask

    task automatic mt_write(input logic hw, input logic lw, input logic [31:0] wd);
        @(negedge clk);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = wd;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] specials[5];
        specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] hi_before;
        bus.start  = 1'b0;
        bus.md_op  = 2'd0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_state", {62'd0, bus.state_dbg}, {62'd0, S_IDLE});
        rst = 1'b1;

        // Directed corner operations
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0); wait_done(33);
        issue(2'd1, 32'hFFFF_FFF9, 32'd3, 1'b0, 32'd0);         wait_done(33);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);         wait_done(33);
        issue(2'd2, 32'd100, 32'd0, 1'b0, 32'd0);               wait_done(33);
        issue(2'd3, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'd0);         wait_done(33);
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0); wait_done(33);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0); wait_done(33);

        // Second start and MTHI while busy are ignored
        issue(2'd0, 32'd123456, 32'd789, 1'b0, 32'd0);
        repeat (4) @(negedge clk);
        bus.start  = 1'b1;
        bus.md_op  = 2'd3;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd1;
        bus.hi_we  = 1'b1;
        bus.wdata  = 32'h1234;
        chk("busy_at_e5", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        chk("busy_after_e5", {63'd0, bus.busy}, 64'd1);
        wait_done(28);
        repeat (3) @(negedge clk);

        // MTHI / MTLO in IDLE
        mt_write(1'b1, 1'b0, 32'hAAAA_0000);
        chk("mthi", {32'd0, bus.hi}, {32'd0, 32'hAAAA_0000});
        mt_write(1'b0, 1'b1, 32'h0000_5555);
        chk("mtlo", {32'd0, bus.lo}, {32'd0, 32'h0000_5555});
        chk("mtlo_hi_kept", {32'd0, bus.hi}, {32'd0, 32'hAAAA_0000});
        mt_write(1'b1, 1'b1, 32'hCAFE_0001);
        chk("mt_both", {bus.hi, bus.lo}, {32'hCAFE_0001, 32'hCAFE_0001});
        mt_write(1'b0, 1'b1, 32'h0000_5555);

        // start with lo_we in the same cycle: the write is dropped
        issue(2'd0, 32'd3, 32'd5, 1'b1, 32'h0000_DEAD);
        chk("lo_we_dropped", {32'd0, bus.lo}, {32'd0, 32'h0000_5555});
        wait_done(33);

        // Reset in the middle of a DIVU
        mt_write(1'b1, 1'b1, 32'hCAFE_0001);
        issue(2'd2, 32'd1000, 32'd7, 1'b0, 32'd0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_hi", {32'd0, bus.hi}, 64'd0);
        chk("abort_lo", {32'd0, bus.lo}, 64'd0);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_state", {62'd0, bus.state_dbg}, {62'd0, S_IDLE});
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'd3, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'd0); wait_done(33);

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                hi_before = $urandom;
                mt_write(1'b1, 1'b0, hi_before);
                chk("rand_mthi", {32'd0, bus.hi}, {32'd0, hi_before});
            end
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 32'd0);
            wait_done(33);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
